// File: rtl/hex_display_pkg.sv
// rtl/hex_display_pkg.sv - shared constants for the 4-digit hex display
// Segment table is {g,f,e,d,c,b,a}, active-low; element n is the code for hex digit n.
package hex_display_pkg;

  localparam logic [31:0] DISP_ADDR = 32'h0000_0020;

  localparam logic [6:0] SEG_OFF = 7'h7F;
  localparam logic [3:0] AN_OFF  = 4'hF;

  localparam logic [15:0][6:0] SEG_TABLE = {
    7'h0E, 7'h06, 7'h21, 7'h46,   // F E d C
    7'h03, 7'h08, 7'h10, 7'h00,   // b A 9 8
    7'h78, 7'h02, 7'h12, 7'h19,   // 7 6 5 4
    7'h30, 7'h24, 7'h79, 7'h40    // 3 2 1 0
  };

endpackage

// File: rtl/hex_display_seg.sv
// rtl/hex_display_seg.sv - combinational nibble to active-low 7-segment decoder
module hex_to_seg
  import hex_display_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] segs_o
);

  assign segs_o = SEG_TABLE[nibble_i];

endmodule

// File: rtl/hex_display.sv
// rtl/hex_display.sv - time-multiplexed 4-digit hex display with per-frame shadow sampling
// The input is captured once per scan frame so a store mid-frame never tears the display.
module hex_display
  import hex_display_pkg::*;
#(
  parameter int DIV      = 1024,
  parameter bit BLANK_LZ = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] data,
  input  logic        en,
  output logic [3:0]  anodes,
  output logic [6:0]  segs,
  output logic        frame
);

  localparam int             PW     = $clog2(DIV);
  localparam logic [PW-1:0]  PS_MAX = PW'(DIV - 1);

  logic [PW-1:0] prescaler_q, prescaler_d;
  logic [1:0]    idx_q, idx_d;
  logic [15:0]   shadow_q, shadow_d;
  logic          primed_q, primed_d;
  logic          frame_q, frame_d;
  logic [3:0]    anodes_q, anodes_d;
  logic [6:0]    segs_q, segs_d;

  logic          tick;
  logic [3:0]    nibble;
  logic [6:0]    seg_code;
  logic          blank;
  logic          lit;

  hex_to_seg u_hex_to_seg (
    .nibble_i (nibble),
    .segs_o   (seg_code)
  );

  assign tick = (prescaler_q == PS_MAX);

  always_comb begin
    prescaler_d = tick ? '0 : prescaler_q + PW'(1);
    idx_d       = tick ? idx_q + 2'd1 : idx_q;
    shadow_d    = shadow_q;
    primed_d    = 1'b1;
    frame_d     = 1'b0;
    // First clock after reset samples immediately; afterwards only at the frame boundary.
    if (!primed_q || (tick && idx_q == 2'd3)) begin
      shadow_d = data;
      frame_d  = 1'b1;
    end
  end

  always_comb begin
    nibble = shadow_q[3:0];
    blank  = 1'b0;
    case (idx_q)
      2'd0: nibble = shadow_q[3:0];
      2'd1: begin
        nibble = shadow_q[7:4];
        blank  = BLANK_LZ && (shadow_q[15:4] == 12'h000);
      end
      2'd2: begin
        nibble = shadow_q[11:8];
        blank  = BLANK_LZ && (shadow_q[15:8] == 8'h00);
      end
      default: begin
        nibble = shadow_q[15:12];
        blank  = BLANK_LZ && (shadow_q[15:12] == 4'h0);
      end
    endcase
    lit      = en && !blank;
    anodes_d = lit ? ~(4'b0001 << idx_q) : AN_OFF;
    segs_d   = lit ? seg_code : SEG_OFF;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prescaler_q <= '0;
      idx_q       <= 2'd0;
      shadow_q    <= 16'h0000;
      primed_q    <= 1'b0;
      frame_q     <= 1'b0;
      anodes_q    <= AN_OFF;
      segs_q      <= SEG_OFF;
    end else begin
      prescaler_q <= prescaler_d;
      idx_q       <= idx_d;
      shadow_q    <= shadow_d;
      primed_q    <= primed_d;
      frame_q     <= frame_d;
      anodes_q    <= anodes_d;
      segs_q      <= segs_d;
    end
  end

  assign anodes = anodes_q;
  assign segs   = segs_q;
  assign frame  = frame_q;

endmodule
